mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Parametrised successor to the single-port byte-serial memory unit.
- Serves NCH independent requesters, e.g. icache refill, LSB load/store and prefetch, over the shared 8-bit RAM/IO bus.
- Arbitration is fixed-priority or round-robin; transfer length is variable up to MAX_BYTES; supports per-channel abort and IO write back-pressure.
- Sits between the cache/LSB layer and the external memory pins.

Parameters:
NCH, 3, number of requester channels (1..8)
MAX_BYTES, 16, largest transfer in bytes; LEN_W = clog2(MAX_BYTES)+1
ARB_MODE, 1, 0 = fixed priority (channel 0 highest), 1 = round-robin
IO_HI, 2'b11, value of addr[17:16] that marks the IO region

Ports:
clk_in  in  1  system clock
rst_in  in  1  asynchronous active-high reset
rdy_in  in  1  global enable; when low, all state and outputs hold
mem_din  in  8  RAM read data, valid one cycle after its address
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART buffer full
req_valid  in  NCH  request pending per channel; held until acked
req_we  in  NCH  1 = write
req_addr  in  NCH*32  start byte address, channel c at bits [32c+31:32c]
req_len  in  NCH*LEN_W  byte count
req_wdata  in  NCH*MAX_BYTES*8  write data, byte i at bits [8i+7:8i] of each channel slice
abort  in  NCH  cancel the channel's in-flight transfer
req_ack  out  NCH  one-cycle pulse: request latched
resp_valid  out  NCH  one-cycle pulse: transfer complete
resp_rdata  out  MAX_BYTES*8  read data of the last completed read
busy  out  1  transfer in progress (not IDLE)

Behaviour:
- Reset (async): state IDLE; mem_a=0, mem_dout=0, mem_wr=0; req_ack=0, resp_valid=0; resp_rdata=0; busy=0; round-robin pointer=0.
- States:
  - IDLE: if any req_valid, grant channel g and latch addr, len, we, wdata. Assert req_ack[g] in the following cycle (registered). Go to XFER with mem_a=addr, byte 0 driven.
  - XFER: drives one byte per cycle. Writes: mem_wr=1, mem_dout = byte i. Reads: mem_wr=0; mem_din is captured into byte i-1 of the read buffer. After the last byte is driven, go to DRAIN (read) or RESP (write).
  - DRAIN: capture the final read byte. mem_wr=0. Go to RESP.
  - RESP: resp_valid[g]=1 for one cycle. Copy the read buffer to resp_rdata, zeroing bytes >= len. Next state is IDLE; no grant is made in RESP.
- Latency: grant at edge E. Address of byte i is on the bus in cycle E+1+i. Read resp_valid is high in cycle E+L+2; write resp_valid in cycle E+L+1. Minimum gap between consecutive grants is L+3 (read) or L+2 (write) cycles.
- Length rules: len 0 is treated as 1; len > MAX_BYTES is clamped to MAX_BYTES.
- Address rules: the address increments per byte except in the IO region (addr[17:16]==IO_HI), where all bytes use the start address.
- IO write back-pressure: in XFER, for an IO write with io_buffer_full=1, drive mem_wr=0 and do not advance; retry each cycle.
- Arbitration:
  - ARB_MODE 0: lowest-index valid channel wins.
  - ARB_MODE 1: first valid channel at or after ptr, wrapping; ptr <= g+1 mod NCH on grant.
  - A channel re-asserting immediately after its response loses to other waiting channels in mode 1.
- Abort:
  - Read in flight (XFER/DRAIN) with abort[g]=1: return to IDLE on the next edge with mem_wr=0; no resp_valid; resp_rdata unchanged.
  - Write in flight: the write completes to preserve memory consistency, but resp_valid is suppressed.
  - abort in RESP suppresses that resp_valid.
  - abort of a non-granted channel has no effect; the requester must drop req_valid itself.
- rdy_in=0 freezes everything, including the io stall check.
- req_valid must stay stable until req_ack; other channels' inputs may change at any time.

Test Plan:
- ch1 read addr 0x100, len 4, RAM bytes 11 22 33 44 -> mem_a 0x100..0x103 on consecutive cycles; resp_valid[1] at E+6; resp_rdata[31:0]=0x44332211, upper bytes 0.
- ch0 write 0x30000 len 1 data 0x41 with io_buffer_full high 3 cycles -> mem_wr=0 for 3 cycles, then one cycle mem_wr=1 with mem_dout=0x41; resp_valid[0] after.
- ARB_MODE 1, all 3 channels valid continuously with len 1 -> grant order 0,1,2,0,1,2. ARB_MODE 0 with same stimulus -> channel 0 always.
- ch0 read len 16, abort[0] at 5th XFER cycle -> IDLE next cycle, no resp_valid, previous resp_rdata retained, next request granted normally.
- ch2 write len 4 with abort mid-transfer -> all 4 bytes written (mem_wr high 4 cycles), resp_valid[2] never asserted.
- Reset asserted mid-XFER, asynchronously between edges -> mem_wr=0, busy=0, outputs zero immediately; req_len=0 and req_len=20 (MAX 16) -> 1-byte and 16-byte transfers.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: multi-channel byte-serial arbiter for the shared 8-bit RAM/IO bus
module mem_arbiter #(
  parameter int NCH = 3,
  parameter int MAX_BYTES = 16,
  parameter int ARB_MODE = 1,
  parameter logic [1:0] IO_HI = 2'b11,
  parameter int LEN_W = $clog2(MAX_BYTES) + 1
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         rdy_in,
  input  logic [7:0]                   mem_din,
  output logic [7:0]                   mem_dout,
  output logic [31:0]                  mem_a,
  output logic                         mem_wr,
  input  logic                         io_buffer_full,
  input  logic [NCH-1:0]               req_valid,
  input  logic [NCH-1:0]               req_we,
  input  logic [NCH*32-1:0]            req_addr,
  input  logic [NCH*LEN_W-1:0]         req_len,
  input  logic [NCH*MAX_BYTES*8-1:0]   req_wdata,
  input  logic [NCH-1:0]               abort,
  output logic [NCH-1:0]               req_ack,
  output logic [NCH-1:0]               resp_valid,
  output logic [MAX_BYTES*8-1:0]       resp_rdata,
  output logic                         busy
);
  localparam int IW = $clog2(MAX_BYTES);
  localparam int CW = NCH > 1 ? $clog2(NCH) : 1;
  typedef enum logic [1:0] {IDLE, XFER, DRAIN, RESP} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] g_q, g_d, ptr_q, ptr_d, gnt;
  logic [IW-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d, rlen;
  logic we_q, we_d, io_q, io_d, kill_q, kill_d, full_q, full_d;
  logic any, abort_g, stall, last;
  logic [31:0] mem_a_q, mem_a_d, raddr;
  logic [MAX_BYTES-1:0][7:0] wbuf_q, wbuf_d, rbuf_q, rbuf_d, rdata_q, rdata_d;
  logic [NCH-1:0] ack_q, ack_d;
  int c;
  // channel selection: lowest index wins, or first valid at/after ptr when rotating
  always_comb begin
    gnt = '0;
    any = 1'b0;
    c = 0;
    for (int k = 0; k < NCH; k++) begin
      c = ARB_MODE != 0 ? (int'(ptr_q) + k) % NCH : k;
      if (!any && |(req_valid & (NCH'(1) << c))) begin
        any = 1'b1;
        gnt = CW'(c);
      end
    end
    abort_g = |(abort & (NCH'(1) << g_q));
    raddr = req_addr[int'(gnt)*32 +: 32];
    rlen = req_len[int'(gnt)*LEN_W +: LEN_W];
    // a frozen cycle reuses the last sampled buffer-full level
    stall = state_q == XFER && we_q && io_q && (rdy_in ? io_buffer_full : full_q);
    last = idx_q == IW'(len_q - LEN_W'(1));
  end
  // next state plus address, byte index and buffer updates
  always_comb begin
    state_d = state_q;
    g_d = g_q;
    ptr_d = ptr_q;
    idx_d = idx_q;
    len_d = len_q;
    we_d = we_q;
    io_d = io_q;
    kill_d = kill_q;
    full_d = io_buffer_full;
    mem_a_d = mem_a_q;
    wbuf_d = wbuf_q;
    rbuf_d = rbuf_q;
    rdata_d = rdata_q;
    ack_d = '0;
    if (state_q == IDLE && any) begin
      state_d = XFER;
      g_d = gnt;
      ptr_d = ARB_MODE != 0 ? (gnt == CW'(NCH - 1) ? '0 : gnt + CW'(1)) : ptr_q;
      idx_d = '0;
      len_d = rlen == '0 ? LEN_W'(1) : (rlen > LEN_W'(MAX_BYTES) ? LEN_W'(MAX_BYTES) : rlen);
      we_d = |(req_we & (NCH'(1) << gnt));
      io_d = raddr[17:16] == IO_HI;
      kill_d = 1'b0;
      mem_a_d = raddr;
      wbuf_d = req_wdata[int'(gnt)*MAX_BYTES*8 +: MAX_BYTES*8];
      ack_d = NCH'(1) << gnt;
    end else if (state_q == XFER) begin
      if (!we_q && abort_g) state_d = IDLE;
      else begin
        kill_d = kill_q | (we_q & abort_g);
        if (!we_q && idx_q != '0) rbuf_d[idx_q - IW'(1)] = mem_din;
        if (!stall && last) state_d = we_q ? RESP : DRAIN;
        else if (!stall) begin
          idx_d = idx_q + IW'(1);
          mem_a_d = io_q ? mem_a_q : mem_a_q + 32'd1;
        end
      end
    end else if (state_q == DRAIN) begin
      if (abort_g) state_d = IDLE;
      else begin
        rbuf_d[idx_q] = mem_din;
        state_d = RESP;
        for (int i = 0; i < MAX_BYTES; i++) rdata_d[i] = LEN_W'(i) < len_q ? rbuf_d[i] : 8'h00;
      end
    end else if (state_q == RESP) state_d = IDLE;
  end
  // state and datapath registers; rdy_in low holds everything
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      g_q <= '0;
      ptr_q <= '0;
      idx_q <= '0;
      len_q <= '0;
      we_q <= 1'b0;
      io_q <= 1'b0;
      kill_q <= 1'b0;
      full_q <= 1'b0;
      mem_a_q <= '0;
      wbuf_q <= '0;
      rbuf_q <= '0;
      rdata_q <= '0;
      ack_q <= '0;
    end else if (rdy_in) begin
      state_q <= state_d;
      g_q <= g_d;
      ptr_q <= ptr_d;
      idx_q <= idx_d;
      len_q <= len_d;
      we_q <= we_d;
      io_q <= io_d;
      kill_q <= kill_d;
      full_q <= full_d;
      mem_a_q <= mem_a_d;
      wbuf_q <= wbuf_d;
      rbuf_q <= rbuf_d;
      rdata_q <= rdata_d;
      ack_q <= ack_d;
    end
  end
  // bus and handshake outputs decoded from the registered state
  always_comb begin
    mem_a = mem_a_q;
    mem_dout = state_q == XFER && we_q ? wbuf_q[idx_q] : 8'h00;
    mem_wr = state_q == XFER && we_q && !stall;
    req_ack = ack_q;
    resp_valid = state_q == RESP && !kill_q && !(rdy_in && abort_g) ? NCH'(1) << g_q : '0;
    resp_rdata = rdata_q;
    busy = state_q != IDLE;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of grant, transfer, abort, back-pressure and reset behaviour
module tb_mem_arbiter;
  localparam int NCH = 3;
  localparam int MB = 16;
  localparam int LW = 5;
  logic clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, io_buffer_full = 1'b0;
  logic [7:0] mem_din = 8'h00, fp_din = 8'h00;
  logic [NCH-1:0] req_valid = '0, req_we = '0, abort = '0;
  logic [NCH*32-1:0] req_addr = '0;
  logic [NCH*LW-1:0] req_len = '0;
  logic [NCH*MB*8-1:0] req_wdata = '0;
  logic [7:0] mem_dout, fp_dout;
  logic [31:0] mem_a, fp_a;
  logic mem_wr, fp_wr, busy, fp_busy;
  logic [NCH-1:0] req_ack, resp_valid, fp_ack, fp_resp;
  logic [MB*8-1:0] resp_rdata, fp_rdata;
  logic [7:0] ram [0:1023];
  logic [7:0] wmem [0:1023];
  int n_vec = 0, n_err = 0;

  mem_arbiter #(.NCH(NCH), .MAX_BYTES(MB), .ARB_MODE(1), .IO_HI(2'b11)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full), .req_valid(req_valid),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .abort(abort),
    .req_ack(req_ack), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .busy(busy));

  mem_arbiter #(.NCH(NCH), .MAX_BYTES(MB), .ARB_MODE(0), .IO_HI(2'b11)) dut_fp (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .mem_din(fp_din), .mem_dout(fp_dout),
    .mem_a(fp_a), .mem_wr(fp_wr), .io_buffer_full(io_buffer_full), .req_valid(req_valid),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata), .abort(abort),
    .req_ack(fp_ack), .resp_valid(fp_resp), .resp_rdata(fp_rdata), .busy(fp_busy));

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_din <= ram[mem_a[9:0]];
    if (mem_wr) wmem[mem_a[9:0]] <= mem_dout;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_req(input int ch, input logic we, input logic [31:0] a, input logic [LW-1:0] l,
                         input logic [MB*8-1:0] wd);
    req_we[ch] = we;
    req_addr[ch*32 +: 32] = a;
    req_len[ch*LW +: LW] = l;
    req_wdata[ch*MB*8 +: MB*8] = wd;
    req_valid[ch] = 1'b1;
  endtask

  // follows one granted transfer (request set in the current cycle) until busy drops
  task automatic run_xfer(input int ch, input int abort_at, output int nwr, output int nresp, output int ncyc);
    nwr = 0;
    nresp = 0;
    ncyc = 0;
    tick;
    req_valid[ch] = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      abort[ch] = (k == abort_at);
      @(negedge clk_in);
      if (mem_wr) nwr++;
      if (resp_valid[ch]) nresp++;
      if (!busy) break;
      ncyc++;
      tick;
    end
    abort = '0;
  endtask

  task automatic test_reset;
    @(negedge clk_in);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_vec++; if (mem_wr !== 1'b0) begin n_err++; $display("FAIL reset_mem_wr: got %b want 0", mem_wr); end
    n_vec++; if (mem_a !== 32'h0) begin n_err++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    n_vec++; if (mem_dout !== 8'h0) begin n_err++; $display("FAIL reset_mem_dout: got %h want 0", mem_dout); end
    n_vec++; if (req_ack !== 3'b000) begin n_err++; $display("FAIL reset_ack: got %b want 000", req_ack); end
    n_vec++; if (resp_valid !== 3'b000) begin n_err++; $display("FAIL reset_resp: got %b want 000", resp_valid); end
    n_vec++; if (resp_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
  endtask

  task automatic test_read;
    tick;
    set_req(1, 1'b0, 32'h100, 5'd4, '0);
    tick;
    req_valid[1] = 1'b0;
    @(negedge clk_in);
    n_vec++; if (req_ack !== 3'b010) begin n_err++; $display("FAIL read_ack: got %b want 010", req_ack); end
    n_vec++; if (mem_a !== 32'h100) begin n_err++; $display("FAIL read_addr0: got %h want 100", mem_a); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL read_busy: got %b want 1", busy); end
    for (int i = 1; i < 4; i++) begin
      tick;
      @(negedge clk_in);
      n_vec++; if (mem_a !== 32'h100 + i) begin n_err++; $display("FAIL read_addr%0d: got %h want %h", i, mem_a, 32'h100 + i); end
      if (i == 1) begin
        n_vec++; if (req_ack !== 3'b000) begin n_err++; $display("FAIL read_ack_pulse: got %b want 000", req_ack); end
      end
    end
    tick;
    @(negedge clk_in);
    n_vec++; if (resp_valid !== 3'b000) begin n_err++; $display("FAIL read_drain_resp: got %b want 000", resp_valid); end
    tick;
    @(negedge clk_in);
    n_vec++; if (resp_valid !== 3'b010) begin n_err++; $display("FAIL read_resp: got %b want 010", resp_valid); end
    n_vec++; if (resp_rdata !== 128'h44332211) begin n_err++; $display("FAIL read_rdata: got %h want 44332211", resp_rdata); end
    tick;
    @(negedge clk_in);
    n_vec++; if (resp_valid !== 3'b000 || busy !== 1'b0) begin n_err++; $display("FAIL read_end: got resp %b busy %b want 000 0", resp_valid, busy); end
  endtask

  task automatic test_abort_read;
    int nwr, nresp, ncyc;
    tick;
    set_req(0, 1'b0, 32'h200, 5'd16, '0);
    run_xfer(0, 5, nwr, nresp, ncyc);
    n_vec++; if (ncyc !== 5) begin n_err++; $display("FAIL abort_read_cycles: got %0d want 5", ncyc); end
    n_vec++; if (nresp !== 0) begin n_err++; $display("FAIL abort_read_resp: got %0d want 0", nresp); end
    n_vec++; if (resp_rdata !== 128'h44332211) begin n_err++; $display("FAIL abort_read_rdata: got %h want 44332211", resp_rdata); end
    tick;
    set_req(2, 1'b0, 32'h104, 5'd2, '0);
    run_xfer(2, 0, nwr, nresp, ncyc);
    n_vec++; if (ncyc !== 4 || nresp !== 1) begin n_err++; $display("FAIL after_abort_read: got cycles %0d resp %0d want 4 1", ncyc, nresp); end
    n_vec++; if (resp_rdata !== 128'h6655) begin n_err++; $display("FAIL after_abort_rdata: got %h want 6655", resp_rdata); end
  endtask

  task automatic test_io_write;
    tick;
    set_req(0, 1'b1, 32'h30000, 5'd1, 128'h41);
    io_buffer_full = 1'b1;
    tick;
    req_valid[0] = 1'b0;
    @(negedge clk_in);
    n_vec++; if (req_ack !== 3'b001) begin n_err++; $display("FAIL io_ack: got %b want 001", req_ack); end
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin tick; @(negedge clk_in); end
      n_vec++; if (mem_wr !== 1'b0 || busy !== 1'b1 || mem_a !== 32'h30000) begin n_err++; $display("FAIL io_stall%0d: got wr %b busy %b a %h want 0 1 30000", k, mem_wr, busy, mem_a); end
    end
    tick;
    io_buffer_full = 1'b0;
    @(negedge clk_in);
    n_vec++; if (mem_wr !== 1'b1 || mem_dout !== 8'h41 || mem_a !== 32'h30000) begin n_err++; $display("FAIL io_write: got wr %b dout %h a %h want 1 41 30000", mem_wr, mem_dout, mem_a); end
    tick;
    @(negedge clk_in);
    n_vec++; if (resp_valid !== 3'b001 || mem_wr !== 1'b0) begin n_err++; $display("FAIL io_resp: got resp %b wr %b want 001 0", resp_valid, mem_wr); end
    tick;
    @(negedge clk_in);
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL io_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_abort_write;
    int nwr, nresp, ncyc;
    tick;
    set_req(2, 1'b1, 32'h500, 5'd4, 128'hA4A3A2A1);
    run_xfer(2, 2, nwr, nresp, ncyc);
    n_vec++; if (nwr !== 4) begin n_err++; $display("FAIL abort_write_bytes: got %0d want 4", nwr); end
    n_vec++; if (nresp !== 0 || ncyc !== 5) begin n_err++; $display("FAIL abort_write_resp: got resp %0d cycles %0d want 0 5", nresp, ncyc); end
    n_vec++; if (wmem[10'h103] !== 8'hA4 || wmem[10'h100] !== 8'hA1) begin n_err++; $display("FAIL abort_write_data: got %h %h want a1 a4", wmem[10'h100], wmem[10'h103]); end
  endtask

  task automatic test_len;
    int nwr, nresp, ncyc;
    logic [MB*8-1:0] wd;
    tick;
    set_req(1, 1'b1, 32'h300, 5'd0, 128'h5A);
    run_xfer(1, 0, nwr, nresp, ncyc);
    n_vec++; if (nwr !== 1 || ncyc !== 2 || nresp !== 1) begin n_err++; $display("FAIL len0_write: got wr %0d cycles %0d resp %0d want 1 2 1", nwr, ncyc, nresp); end
    n_vec++; if (wmem[10'h300] !== 8'h5A) begin n_err++; $display("FAIL len0_data: got %h want 5a", wmem[10'h300]); end
    for (int i = 0; i < MB; i++) wd[i*8 +: 8] = 8'h10 + 8'(i);
    tick;
    set_req(1, 1'b1, 32'h310, 5'd20, wd);
    run_xfer(1, 0, nwr, nresp, ncyc);
    n_vec++; if (nwr !== 16 || ncyc !== 17 || nresp !== 1) begin n_err++; $display("FAIL len20_write: got wr %0d cycles %0d resp %0d want 16 17 1", nwr, ncyc, nresp); end
    n_vec++; if (wmem[10'h310] !== 8'h10 || wmem[10'h31F] !== 8'h1F) begin n_err++; $display("FAIL len20_data: got %h %h want 10 1f", wmem[10'h310], wmem[10'h31F]); end
    tick;
    set_req(0, 1'b0, 32'h100, 5'd0, '0);
    run_xfer(0, 0, nwr, nresp, ncyc);
    n_vec++; if (ncyc !== 3 || nresp !== 1) begin n_err++; $display("FAIL len0_read: got cycles %0d resp %0d want 3 1", ncyc, nresp); end
    n_vec++; if (resp_rdata !== 128'h11) begin n_err++; $display("FAIL len0_rdata: got %h want 11", resp_rdata); end
  endtask

  task automatic test_arb;
    logic [NCH-1:0] rr [6];
    logic [NCH-1:0] fp [6];
    int nr = 0, nf = 0;
    for (int i = 0; i < 6; i++) begin rr[i] = '0; fp[i] = '0; end
    rst_in = 1'b1;
    tick;
    tick;
    rst_in = 1'b0;
    tick;
    for (int ch = 0; ch < NCH; ch++) set_req(ch, 1'b0, 32'h0, 5'd1, '0);
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_in);
      if (req_ack != '0 && nr < 6) begin rr[nr] = req_ack; nr++; end
      if (fp_ack != '0 && nf < 6) begin fp[nf] = fp_ack; nf++; end
      tick;
    end
    req_valid = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_in);
      if (!busy && !fp_busy) break;
      tick;
    end
    for (int i = 0; i < 6; i++) begin
      n_vec++; if (rr[i] !== 3'b001 << (i % 3)) begin n_err++; $display("FAIL rr_grant%0d: got %b want %b", i, rr[i], 3'b001 << (i % 3)); end
      n_vec++; if (fp[i] !== 3'b001) begin n_err++; $display("FAIL fp_grant%0d: got %b want 001", i, fp[i]); end
    end
  endtask

  task automatic test_async_reset;
    tick;
    set_req(1, 1'b1, 32'h400, 5'd8, 128'h0807060504030201);
    tick;
    req_valid[1] = 1'b0;
    tick;
    tick;
    n_vec++; if (mem_wr !== 1'b1 || busy !== 1'b1) begin n_err++; $display("FAIL pre_reset_xfer: got wr %b busy %b want 1 1", mem_wr, busy); end
    #2;
    rst_in = 1'b1;
    #1;
    n_vec++; if (mem_wr !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL async_reset_ctrl: got wr %b busy %b want 0 0", mem_wr, busy); end
    n_vec++; if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin n_err++; $display("FAIL async_reset_bus: got a %h dout %h want 0 0", mem_a, mem_dout); end
    n_vec++; if (req_ack !== '0 || resp_valid !== '0 || resp_rdata !== '0) begin n_err++; $display("FAIL async_reset_resp: got ack %b resp %b rdata %h want 0", req_ack, resp_valid, resp_rdata); end
    tick;
    tick;
    rst_in = 1'b0;
    tick;
    @(negedge clk_in);
    n_vec++; if (busy !== 1'b0 || mem_wr !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got busy %b wr %b want 0 0", busy, mem_wr); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i) ^ 8'h5A;
    ram[10'h100] = 8'h11;
    ram[10'h101] = 8'h22;
    ram[10'h102] = 8'h33;
    ram[10'h103] = 8'h44;
    ram[10'h104] = 8'h55;
    ram[10'h105] = 8'h66;
    tick;
    test_reset;
    tick;
    rst_in = 1'b0;
    test_read;
    test_abort_read;
    test_io_write;
    test_abort_write;
    test_len;
    test_arb;
    test_async_reset;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
